// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 SPI sink: command ROM, sizes and state encodings.
package oled_pkg;

  localparam int OLED_INIT_LEN = 25;
  localparam int OLED_ADDR_LEN = 6;
  localparam int OLED_CMD_LEN  = OLED_INIT_LEN + OLED_ADDR_LEN;

  typedef enum logic [2:0] {
    S_RES_LOW  = 3'd0,
    S_RES_WAIT = 3'd1,
    S_INIT     = 3'd2,
    S_IDLE     = 3'd3,
    S_DATA     = 3'd4,
    S_SYNC     = 3'd5
  } sink_state_t;

  // Byte transmitter phases: cs_n high with dc/mosi set up, cs_n low lead-in, then SCLK high/low per bit.
  typedef enum logic [1:0] {
    P_SETUP = 2'd0,
    P_LEAD  = 2'd1,
    P_HI    = 2'd2,
    P_LO    = 2'd3
  } tx_phase_t;

  // Panel bring-up bytes (indices 0..24) followed by the address-reset bytes (25..30).
  function automatic logic [7:0] oled_cmd_rom(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'hD5;
      5'd2:  b = 8'h80;
      5'd3:  b = 8'hA8;
      5'd4:  b = 8'h1F;
      5'd5:  b = 8'hD3;
      5'd6:  b = 8'h00;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;
      5'd9:  b = 8'h14;
      5'd10: b = 8'h20;
      5'd11: b = 8'h00;
      5'd12: b = 8'hA1;
      5'd13: b = 8'hC8;
      5'd14: b = 8'hDA;
      5'd15: b = 8'h02;
      5'd16: b = 8'h81;
      5'd17: b = 8'h8F;
      5'd18: b = 8'hD9;
      5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;
      5'd21: b = 8'h40;
      5'd22: b = 8'hA4;
      5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
      5'd25: b = 8'h21;
      5'd26: b = 8'h00;
      5'd27: b = 8'h7F;
      5'd28: b = 8'h22;
      5'd29: b = 8'h00;
      5'd30: b = 8'h03;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-0 byte serialiser: one byte per start pulse, 18*CLK_DIV cycles per byte, MSB first.
module oled_spi_byte_tx import oled_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       spi_dc
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  tx_phase_t      phase_r;
  logic [CW-1:0]  div_cnt_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           busy_r;
  logic           sclk_r;
  logic           mosi_r;
  logic           cs_n_r;
  logic           dc_r;
  logic           phase_end_s;

  assign phase_end_s = (div_cnt_r == DIV_LAST);
  // done marks the cycle whose closing edge raises cs_n, so the sequencer can react on that same edge
  assign done   = busy_r && (phase_r == P_LO) && (bit_idx_r == 3'd7) && phase_end_s;
  assign busy   = busy_r;
  assign sclk   = sclk_r;
  assign mosi   = mosi_r;
  assign cs_n   = cs_n_r;
  assign spi_dc = dc_r;

  // Phase sequencer: each phase lasts CLK_DIV cycles; SCLK edges and cs_n changes happen at phase ends.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      phase_r   <= P_SETUP;
      div_cnt_r <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      busy_r    <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      dc_r      <= 1'b0;
    end else if (!busy_r) begin
      div_cnt_r <= '0;
      if (start) begin
        busy_r    <= 1'b1;
        phase_r   <= P_SETUP;
        bit_idx_r <= 3'd0;
        mosi_r    <= tx_byte[7];
        shift_r   <= {tx_byte[6:0], 1'b0};
        dc_r      <= dc;
      end
    end else if (!phase_end_s) begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end else begin
      div_cnt_r <= '0;
      case (phase_r)
        P_SETUP: begin
          cs_n_r  <= 1'b0;
          phase_r <= P_LEAD;
        end
        P_LEAD: begin
          sclk_r  <= 1'b1;
          phase_r <= P_HI;
        end
        P_HI: begin
          sclk_r  <= 1'b0;
          phase_r <= P_LO;
          if (bit_idx_r != 3'd7) begin
            mosi_r  <= shift_r[7];
            shift_r <= {shift_r[6:0], 1'b0};
          end
        end
        P_LO: begin
          if (bit_idx_r == 3'd7) begin
            cs_n_r  <= 1'b1;
            busy_r  <= 1'b0;
            phase_r <= P_SETUP;
          end else begin
            sclk_r    <= 1'b1;
            bit_idx_r <= bit_idx_r + 3'd1;
            phase_r   <= P_HI;
          end
        end
        default: begin
          phase_r <= P_SETUP;
          busy_r  <= 1'b0;
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink_chk.sv
// Protocol checker for the streamer-facing handshake of ssd1306_spi_sink.
module ssd1306_spi_sink_chk (
  input logic clk_in,
  input logic reset_n_in,
  input logic ready_out,
  input logic write_stb_in,
  input logic sync_stb_in
);

  // Write and sync strobes must never be presented together while the sink is ready.
  a_no_dual_strobe: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    !(ready_out && write_stb_in && sync_stb_in))
    else $error("dual strobe while ready");

endmodule

// File: rtl/ssd1306_spi_sink.sv
// SSD1306 128x32 SPI sink: panel reset and init, then one SPI byte per write strobe, address reset per sync.
module ssd1306_spi_sink import oled_pkg::*; #(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic [7:0] data_in,
  input  logic       write_stb_in,
  input  logic       sync_stb_in,
  output logic       ready_out,
  output logic       oled_sclk_out,
  output logic       oled_mosi_out,
  output logic       oled_cs_n_out,
  output logic       oled_dc_out,
  output logic       oled_res_n_out
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam logic [RCW-1:0] RES_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [4:0] ADDR_FIRST = 5'(OLED_INIT_LEN);
  localparam logic [4:0] CMD_LAST   = 5'(OLED_CMD_LEN - 1);

  sink_state_t    state_r;
  logic [RCW-1:0] res_cnt_r;
  logic [4:0]     idx_r;
  logic           start_r;
  logic [7:0]     tx_byte_r;
  logic           tx_dc_r;
  logic           ready_r;
  logic           res_n_r;
  logic           tx_busy_s;
  logic           tx_done_s;

  assign ready_out      = ready_r;
  assign oled_res_n_out = res_n_r;

  oled_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .start      (start_r),
    .tx_byte    (tx_byte_r),
    .dc         (tx_dc_r),
    .busy       (tx_busy_s),
    .done       (tx_done_s),
    .sclk       (oled_sclk_out),
    .mosi       (oled_mosi_out),
    .cs_n       (oled_cs_n_out),
    .spi_dc     (oled_dc_out)
  );

  // Top sequencer: panel reset timing, command streaming, and the idle handshake with the streamer.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r   <= S_RES_LOW;
      res_cnt_r <= '0;
      idx_r     <= 5'd0;
      start_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      tx_dc_r   <= 1'b0;
      ready_r   <= 1'b0;
      res_n_r   <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        S_RES_LOW: begin
          if (res_cnt_r == RES_LAST) begin
            res_cnt_r <= '0;
            res_n_r   <= 1'b1;
            state_r   <= S_RES_WAIT;
          end else begin
            res_cnt_r <= res_cnt_r + RCW'(1);
          end
        end
        S_RES_WAIT: begin
          if (res_cnt_r == RES_LAST) begin
            res_cnt_r <= '0;
            idx_r     <= 5'd0;
            start_r   <= 1'b1;
            tx_byte_r <= oled_cmd_rom(5'd0);
            tx_dc_r   <= 1'b0;
            state_r   <= S_INIT;
          end else begin
            res_cnt_r <= res_cnt_r + RCW'(1);
          end
        end
        // Init and sync share the ROM walk; sync simply starts at the first address-reset byte.
        S_INIT, S_SYNC: begin
          if (tx_done_s) begin
            if (idx_r == CMD_LAST) begin
              idx_r   <= 5'd0;
              ready_r <= 1'b1;
              state_r <= S_IDLE;
            end else begin
              idx_r     <= idx_r + 5'd1;
              start_r   <= 1'b1;
              tx_byte_r <= oled_cmd_rom(idx_r + 5'd1);
            end
          end
        end
        S_IDLE: begin
          if (!tx_busy_s && write_stb_in) begin
            ready_r   <= 1'b0;
            start_r   <= 1'b1;
            tx_byte_r <= data_in;
            tx_dc_r   <= 1'b1;
            state_r   <= S_DATA;
          end else if (!tx_busy_s && sync_stb_in) begin
            ready_r   <= 1'b0;
            start_r   <= 1'b1;
            idx_r     <= ADDR_FIRST;
            tx_byte_r <= oled_cmd_rom(ADDR_FIRST);
            tx_dc_r   <= 1'b0;
            state_r   <= S_SYNC;
          end
        end
        S_DATA: begin
          if (tx_done_s) begin
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_RES_LOW;
          ready_r <= 1'b0;
          res_n_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
